// File: rtl/mem_stage.sv
// mem_stage -- memory-access stage between the EX/MEM and MEM/WB pipe registers.
// Issues loads/stores on a req/ack data-memory port, lane-aligns store data and
// byte enables, extends load data, and passes ALU results through for other ops.
// An outstanding access holds EX/MEM through o_stall; a missing ack is aborted
// after ACK_TIMEOUT busy cycles with a bus-error pulse.
// Ports:
//   i_clk, i_rst            clock (rising edge), async active-low reset
//   i_rs_2, i_rd_num,
//   i_alu_out, i_opcode,
//   i_func_3                instruction fields from EX/MEM
//   i_dmem_ack/rdata        memory completion and read word
//   o_dmem_*                memory request, write enable, word address, data, byte enables
//   o_stall                 combinational hold for EX/MEM
//   o_valid, o_rd_num,
//   o_wb_data, o_wb_en      registered MEM/WB results
//   o_misalign, o_bus_err   registered one-cycle error pulses
module mem_stage #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_rs_2,
  input  logic [4:0]  i_rd_num,
  input  logic [31:0] i_alu_out,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_func_3,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_be,
  output logic        o_stall,
  output logic        o_valid,
  output logic [4:0]  o_rd_num,
  output logic [31:0] o_wb_data,
  output logic        o_wb_en,
  output logic        o_misalign,
  output logic        o_bus_err
);

  localparam int         CNT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} state_t;

  state_t             state_r, state_next_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [2:0]         f3_r;
  logic [1:0]         off_r;
  logic [4:0]         rd_r;
  logic               is_load_s, is_store_s, is_mem_s, f3_ok_s, misalign_s, start_s;
  logic               ack_done_s, timeout_s, stall_s;

  // Byte enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   store_be = 4'b0001 << off;
      2'b01:   store_be = off[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Store data replicated across all lanes so the byte enables pick the lane.
  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    case (f3[1:0])
      2'b00:   store_wdata = {4{rs2[7:0]}};
      2'b01:   store_wdata = {2{rs2[15:0]}};
      default: store_wdata = rs2;
    endcase
  endfunction

  // Select the addressed byte/half from the read word and sign/zero extend it.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b100:  load_extend = {24'h000000, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b101:  load_extend = {16'h0000, h};
      default: load_extend = rdata;
    endcase
  endfunction

  // Decode the incoming instruction: memory op, legal size code, alignment.
  always_comb begin
    is_load_s  = (i_opcode == OP_LOAD);
    is_store_s = (i_opcode == OP_STORE);
    is_mem_s   = is_load_s | is_store_s;
    if (is_load_s) begin
      f3_ok_s = (i_func_3 != 3'b011) && (i_func_3 != 3'b110) && (i_func_3 != 3'b111);
    end else begin
      f3_ok_s = (i_func_3[2] == 1'b0) && (i_func_3[1:0] != 2'b11);
    end
    misalign_s = ((i_func_3[1:0] == 2'b01) && i_alu_out[0]) ||
                 ((i_func_3[1:0] == 2'b10) && (i_alu_out[1:0] != 2'b00));
    start_s    = (state_r == ST_IDLE) && is_mem_s && f3_ok_s && !misalign_s;
  end

  // Next-state logic; ack is checked before timeout so a last-cycle ack wins.
  always_comb begin
    state_next_s = state_r;
    ack_done_s   = 1'b0;
    timeout_s    = 1'b0;
    stall_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_next_s = ST_BUSY;
          stall_s      = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        stall_s = 1'b1;
        if (i_dmem_ack) begin
          ack_done_s   = 1'b1;
          state_next_s = ST_DONE;
        end else if (cnt_r == CNT_W'(ACK_TIMEOUT - 1)) begin
          timeout_s    = 1'b1;
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_BUSY;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Stall is gated by reset so every output reads 0 while reset is held.
  assign o_stall = stall_s & i_rst;

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_r <= ST_IDLE;
    else        state_r <= state_next_s;
  end

  // Busy-cycle counter: counts while waiting for ack, cleared otherwise.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                 cnt_r <= '0;
    else if (state_r == ST_BUSY) cnt_r <= cnt_r + CNT_W'(1);
    else                        cnt_r <= '0;
  end

  // Memory port, latched access context and MEM/WB outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_dmem_req   <= 1'b0;
      o_dmem_we    <= 1'b0;
      o_dmem_addr  <= 32'h0;
      o_dmem_wdata <= 32'h0;
      o_dmem_be    <= 4'h0;
      o_valid      <= 1'b0;
      o_rd_num     <= 5'd0;
      o_wb_data    <= 32'h0;
      o_wb_en      <= 1'b0;
      o_misalign   <= 1'b0;
      o_bus_err    <= 1'b0;
      f3_r         <= 3'd0;
      off_r        <= 2'd0;
      rd_r         <= 5'd0;
    end else begin
      o_misalign <= 1'b0;
      o_bus_err  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            o_dmem_req   <= 1'b1;
            o_dmem_we    <= is_store_s;
            o_dmem_addr  <= {i_alu_out[31:2], 2'b00};
            o_dmem_be    <= is_store_s ? store_be(i_func_3, i_alu_out[1:0]) : 4'b1111;
            o_dmem_wdata <= is_store_s ? store_wdata(i_func_3, i_rs_2) : 32'h0;
            f3_r         <= i_func_3;
            off_r        <= i_alu_out[1:0];
            rd_r         <= i_rd_num;
            o_valid      <= 1'b0;
            o_wb_en      <= 1'b0;
          end else if (is_mem_s) begin
            // Illegal size or misaligned: retire without access or writeback.
            o_valid    <= 1'b1;
            o_wb_en    <= 1'b0;
            o_rd_num   <= i_rd_num;
            o_misalign <= f3_ok_s & misalign_s;
          end else begin
            o_valid   <= 1'b1;
            o_wb_data <= i_alu_out;
            o_rd_num  <= i_rd_num;
            o_wb_en   <= (i_rd_num != 5'd0);
          end
        end
        ST_BUSY: begin
          if (ack_done_s) begin
            o_dmem_req <= 1'b0;
            o_valid    <= 1'b1;
            o_rd_num   <= rd_r;
            if (!o_dmem_we) begin
              o_wb_data <= load_extend(f3_r, off_r, i_dmem_rdata);
              o_wb_en   <= (rd_r != 5'd0);
            end else begin
              o_wb_en <= 1'b0;
            end
          end else if (timeout_s) begin
            o_dmem_req <= 1'b0;
            o_bus_err  <= 1'b1;
            o_valid    <= 1'b1;
            o_wb_en    <= 1'b0;
          end else begin
            o_valid <= 1'b0;
          end
        end
        ST_DONE: begin
          o_valid <= 1'b0;
          o_wb_en <= 1'b0;
        end
        default: begin
          o_dmem_req <= 1'b0;
          o_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- directed and random stimulus for mem_stage, checked against a
// behavioural model of the access rules (size/alignment classes, lane arithmetic,
// stall-cycle count) kept inside the bench.
module tb_mem_stage;

  localparam int         TO       = 4;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ADD   = 7'b0110011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;

  logic        i_clk, i_rst;
  logic [31:0] i_rs_2, i_alu_out, i_dmem_rdata;
  logic [4:0]  i_rd_num;
  logic [6:0]  i_opcode;
  logic [2:0]  i_func_3;
  logic        i_dmem_ack;
  logic        o_dmem_req, o_dmem_we, o_stall, o_valid, o_wb_en, o_misalign, o_bus_err;
  logic [31:0] o_dmem_addr, o_dmem_wdata, o_wb_data;
  logic [3:0]  o_dmem_be;
  logic [4:0]  o_rd_num;

  int n_cmp = 0;
  int n_bad = 0;

  mem_stage #(.ACK_TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rs_2(i_rs_2), .i_rd_num(i_rd_num),
    .i_alu_out(i_alu_out), .i_opcode(i_opcode), .i_func_3(i_func_3),
    .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be), .o_stall(o_stall),
    .o_valid(o_valid), .o_rd_num(o_rd_num), .o_wb_data(o_wb_data), .o_wb_en(o_wb_en),
    .o_misalign(o_misalign), .o_bus_err(o_bus_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // 0 = non-memory, 1 = no access (illegal size), 2 = misaligned, 3 = real access
  function automatic int classify(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    if (op != OP_LOAD && op != OP_STORE) return 0;
    if (op == OP_LOAD  && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1;
    if (op == OP_STORE && f3 > 3'd2) return 1;
    sz = 1 << f3[1:0];
    if ((a % sz) != 0) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rdata);
    longint v, bits;
    bits = 8 * (1 << f3[1:0]);
    v = longint'(rdata) >> (8 * (a % 4));
    if (bits < 32) begin
      v = v % (64'd1 << bits);
      if (!f3[2] && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
    end
    return v[31:0];
  endfunction

  task automatic drive_nop();
    i_opcode = OP_ADDI; i_func_3 = 3'd0; i_alu_out = 32'h0; i_rd_num = 5'd0; i_rs_2 = 32'h0;
  endtask

  task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] rs2, input logic [4:0] rd, input int ack_dly,
                        input logic [31:0] rdata);
    int c, sz, stalls, exp_stalls;
    logic [31:0] exp_wd;
    logic [3:0]  exp_be;
    logic        acked;
    @(negedge i_clk);
    i_opcode = op; i_func_3 = f3; i_alu_out = a; i_rs_2 = rs2; i_rd_num = rd; i_dmem_ack = 1'b0;
    #1;
    c = classify(op, f3, a);
    stalls = o_stall ? 1 : 0;
    chk("stall_idle", o_stall, (c == 3));
    if (c != 3) begin
      @(negedge i_clk);
      chk("valid_imm", o_valid, 1);
      chk("req_none", o_dmem_req, 0);
      chk("misalign", o_misalign, (c == 2));
      chk("bus_err_imm", o_bus_err, 0);
      chk("wb_en_imm", o_wb_en, (c == 0) && (rd != 5'd0));
      chk("rd_imm", o_rd_num, rd);
      if (c == 0) chk("wb_data_alu", o_wb_data, a);
      drive_nop();
      @(negedge i_clk);
      chk("misalign_clear", o_misalign, 0);
    end else begin
      sz = 1 << f3[1:0];
      if (op == OP_STORE) begin
        exp_be = 4'(((1 << sz) - 1) << (a % 4));
        exp_wd = (sz == 1) ? rs2[7:0] * 32'h01010101 :
                 (sz == 2) ? rs2[15:0] * 32'h00010001 : rs2;
      end else begin
        exp_be = 4'hF;
        exp_wd = 32'h0;
      end
      @(negedge i_clk);
      chk("req_set", o_dmem_req, 1);
      chk("we", o_dmem_we, (op == OP_STORE));
      chk("addr", o_dmem_addr, a - (a % 4));
      chk("be", o_dmem_be, exp_be);
      if (op == OP_STORE) chk("wdata", o_dmem_wdata, exp_wd);
      chk("valid_busy", o_valid, 0);
      acked = 1'b0;
      for (int k = 0; k < TO; k++) begin
        if (o_stall) stalls++;
        chk("req_held", o_dmem_req, 1);
        if (k == ack_dly) begin
          i_dmem_ack = 1'b1; i_dmem_rdata = rdata;
        end
        @(negedge i_clk);
        i_dmem_ack = 1'b0;
        if (k == ack_dly) begin
          acked = 1'b1;
          break;
        end
      end
      exp_stalls = (ack_dly < TO) ? ack_dly + 2 : TO + 1;
      chk("stall_cycles", stalls, exp_stalls);
      chk("stall_done", o_stall, 0);
      chk("valid_done", o_valid, 1);
      chk("req_drop", o_dmem_req, 0);
      chk("bus_err", o_bus_err, !acked);
      chk("wb_en_done", o_wb_en, acked && (op == OP_LOAD) && (rd != 5'd0));
      if (acked) chk("rd_done", o_rd_num, rd);
      if (acked && op == OP_LOAD) chk("load_data", o_wb_data, exp_load(f3, a, rdata));
      i_dmem_ack = 1'($urandom_range(0, 1));   // must be ignored in DONE
      @(negedge i_clk);
      i_dmem_ack = 1'b0;
      chk("valid_clear", o_valid, 0);
      chk("bus_err_clear", o_bus_err, 0);
      chk("req_idle", o_dmem_req, 0);
      drive_nop();
    end
  endtask

  initial begin
    i_rst = 1'b0; i_dmem_ack = 1'b1; i_dmem_rdata = 32'hDEADBEEF;
    i_opcode = OP_LOAD; i_func_3 = 3'd2; i_alu_out = 32'h100; i_rs_2 = 32'h0; i_rd_num = 5'd3;
    #12;
    chk("rst_req", o_dmem_req, 0);
    chk("rst_stall", o_stall, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_wb_en", o_wb_en, 0);
    chk("rst_wb_data", o_wb_data, 0);
    chk("rst_be", o_dmem_be, 0);
    chk("rst_errs", {o_misalign, o_bus_err}, 0);
    @(negedge i_clk);
    i_dmem_ack = 1'b0; drive_nop();
    i_rst = 1'b1;

    run_op(OP_ADD,   3'd0, 32'h1234,   32'h0,  5'd5, 0, 32'h0);        // ADD passthrough
    run_op(OP_STORE, 3'd0, 32'h103,    32'hAB, 5'd0, 3, 32'h0);        // SB, ack after 3
    run_op(OP_LOAD,  3'd0, 32'h102,    32'h0,  5'd7, 0, 32'h00800000); // LB
    run_op(OP_LOAD,  3'd4, 32'h102,    32'h0,  5'd7, 0, 32'h00800000); // LBU
    run_op(OP_LOAD,  3'd2, 32'h101,    32'h0,  5'd7, 0, 32'h0);        // LW misaligned
    run_op(OP_LOAD,  3'd1, 32'h202,    32'h0,  5'd9, 99, 32'h0);       // LH timeout
    run_op(OP_STORE, 3'd1, 32'h302,    32'h1234ABCD, 5'd1, 1, 32'h0);  // SH upper half
    run_op(OP_LOAD,  3'd5, 32'h402,    32'h0,  5'd4, 3, 32'h8001FFFF); // HU, ack on last cycle
    run_op(OP_LOAD,  3'd3, 32'h400,    32'h0,  5'd4, 0, 32'h0);        // illegal load size
    run_op(OP_STORE, 3'd4, 32'h400,    32'h0,  5'd4, 0, 32'h0);        // illegal store size

    // Reset in the middle of a busy access, then a late ack after release.
    @(negedge i_clk);
    i_opcode = OP_LOAD; i_func_3 = 3'd2; i_alu_out = 32'h200; i_rd_num = 5'd6;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    chk("midrst_req", o_dmem_req, 0);
    chk("midrst_valid", o_valid, 0);
    chk("midrst_stall", o_stall, 0);
    chk("midrst_errs", {o_misalign, o_bus_err}, 0);
    @(negedge i_clk);
    i_rst = 1'b1; drive_nop();
    @(negedge i_clk);
    i_dmem_ack = 1'b1; i_dmem_rdata = 32'h12345678;
    @(negedge i_clk);
    i_dmem_ack = 1'b0;
    chk("late_ack_req", o_dmem_req, 0);
    chk("late_ack_err", o_bus_err, 0);
    chk("late_ack_wb_en", o_wb_en, 0);
    chk("late_ack_wb_data", o_wb_data, 0);
    chk("late_ack_stall", o_stall, 0);

    for (int n = 0; n < 60; n++) begin
      logic [6:0] op;
      case ($urandom_range(0, 2))
        0:       op = OP_ADD;
        1:       op = OP_LOAD;
        default: op = OP_STORE;
      endcase
      run_op(op, 3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)),
             int'($urandom_range(0, 4)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
